// File: rtl/neo_bit_encoder_if.sv
// Pixel command channel from the strand controller into the NeoPixel bit encoder.
// Carries one 24-bit {G,R,B} word plus end-of-frame marker under valid/ready.
interface neo_bit_encoder_if;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_last;
  logic        pixel_ready;

  modport master (
    output pixel_data,
    output pixel_valid,
    output pixel_last,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    input  pixel_last,
    output pixel_ready
  );
endinterface

// File: rtl/neo_bit_encoder.sv
// NeoPixel single-wire encoder: serialises {G,R,B} words MSB first, then holds a latch gap.
// Latency: neo_data rises on the accept edge; 24*T_BIT cycles per pixel, T_LATCH low after a frame.
// Backpressure: pixel_ready only in IDLE or on the last cycle of a non-final pixel. Option: NEO_UNDERRUN_DETECT_EN.
module neo_bit_encoder #(
  parameter int T0H     = 18,
  parameter int T1H     = 35,
  parameter int T_BIT   = 63,
  parameter int T_LATCH = 2750
) (
  input  logic              clock,
  input  logic              reset_n,
  neo_bit_encoder_if.slave  pix,
  output logic              neo_data,
  output logic              busy,
  output logic              latch_done,
  output logic              underrun
);

  localparam int CW = $clog2(T_BIT);
  localparam int LW = $clog2(T_LATCH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HIGH_1   = CW'(T1H);
  localparam logic [CW-1:0] HIGH_0   = CW'(T0H);
  localparam logic [LW-1:0] LAT_LAST = LW'(T_LATCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          last_q, last_d;
  logic          neo_q, neo_d;
  logic          ready_c;
  logic          accept_c;
  logic          end_of_pixel_c;

  assign end_of_pixel_c = (state_q == BIT) && (idx_q == 5'd0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    lcnt_d     = lcnt_q;
    last_d     = last_q;
    latch_done = 1'b0;

    ready_c  = (state_q == IDLE) || (end_of_pixel_c && !last_q);
    accept_c = pix.pixel_valid && ready_c;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = BIT;
          shift_d = pix.pixel_data;
          idx_d   = 5'd23;
          cnt_d   = '0;
          last_d  = pix.pixel_last;
        end
      end
      BIT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (idx_q != 5'd0) begin
          shift_d = {shift_q[22:0], 1'b0};
          idx_d   = idx_q - 1'b1;
          cnt_d   = '0;
        end else if (!last_q && accept_c) begin
          // Back-to-back pixel: reload without a gap cycle.
          shift_d = pix.pixel_data;
          idx_d   = 5'd23;
          cnt_d   = '0;
          last_d  = pix.pixel_last;
        end else begin
          state_d = LATCH;
          lcnt_d  = '0;
        end
      end
      LATCH: begin
        if (lcnt_q == LAT_LAST) begin
          latch_done = 1'b1;
          state_d    = IDLE;
          lcnt_d     = '0;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output is derived from next-state so the line rises on the same edge that accepts.
    neo_d = (state_d == BIT) && (cnt_d < (shift_d[23] ? HIGH_1 : HIGH_0));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      lcnt_q  <= '0;
      last_q  <= 1'b0;
      neo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lcnt_q  <= lcnt_d;
      last_q  <= last_d;
      neo_q   <= neo_d;
    end
  end

  assign pix.pixel_ready = ready_c;
  assign neo_data        = neo_q;
  assign busy            = (state_q != IDLE);

`ifdef NEO_UNDERRUN_DETECT_EN
  logic underrun_q, underrun_d;

  // Non-final pixel ended with nothing offered: sticky until reset.
  always_comb begin
    underrun_d = underrun_q | (end_of_pixel_c && !last_q && !pix.pixel_valid);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_neo_bit_encoder.sv
// Bench for neo_bit_encoder: directed frames plus random traffic against a sample-queue reference.
// A second, small-parameter instance checks the overridden timing directly.
module tb_neo_bit_encoder;

  localparam int T0H     = 18;
  localparam int T1H     = 35;
  localparam int T_BIT   = 63;
  localparam int T_LATCH = 2750;

  logic clock = 1'b0;
  always #10 clock = ~clock;

  logic reset_n;
  logic neo_data, busy, latch_done, underrun;
  logic s_neo_data, s_busy, s_latch_done, s_underrun;

  neo_bit_encoder_if pif ();
  neo_bit_encoder_if sif ();

  neo_bit_encoder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pix        (pif),
    .neo_data   (neo_data),
    .busy       (busy),
    .latch_done (latch_done),
    .underrun   (underrun)
  );

  neo_bit_encoder #(
    .T0H     (2),
    .T1H     (4),
    .T_BIT   (6),
    .T_LATCH (10)
  ) dut_s (
    .clock      (clock),
    .reset_n    (reset_n),
    .pix        (sif),
    .neo_data   (s_neo_data),
    .busy       (s_busy),
    .latch_done (s_latch_done),
    .underrun   (s_underrun)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: queue of expected {neo_data, latch_done} per future cycle; empty means IDLE.
  logic [1:0] exp_q[$];
  bit         in_pixel = 1'b0;
  bit         cur_last = 1'b0;
  bit         exp_und  = 1'b0;

  task automatic push_pixel(input logic [23:0] px);
    for (int b = 0; b < 24; b++) begin
      logic bt;
      bt = px[23 - b];
      for (int c = 0; c < T_BIT; c++) begin
        exp_q.push_back({(c < (bt ? T1H : T0H)) ? 1'b1 : 1'b0, 1'b0});
      end
    end
  endtask

  task automatic push_latch();
    for (int i = 0; i < T_LATCH; i++) begin
      exp_q.push_back({1'b0, (i == T_LATCH - 1) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic step(input logic v, input logic [23:0] d, input logic l, input logic r);
    logic       busy_e, rdy_e, acc;
    logic [1:0] cur;
    @(negedge clock);
    reset_n         = r;
    pif.pixel_valid = v;
    pif.pixel_data  = d;
    pif.pixel_last  = l;
    #1;
    busy_e = (exp_q.size() != 0);
    cur    = busy_e ? exp_q[0] : 2'b00;
    rdy_e  = !busy_e || (in_pixel && exp_q.size() == 1 && !cur_last);
    check("pixel_ready", pif.pixel_ready, rdy_e);
    check("neo_data",    neo_data,        cur[1]);
    check("latch_done",  latch_done,      cur[0]);
    check("busy",        busy,            busy_e);
    check("underrun",    underrun,        exp_und);
    if (!r) begin
      exp_q.delete();
      in_pixel = 1'b0;
      cur_last = 1'b0;
      exp_und  = 1'b0;
    end else begin
      acc = v && rdy_e;
      if (busy_e) void'(exp_q.pop_front());
      if (acc) begin
        push_pixel(d);
        in_pixel = 1'b1;
        cur_last = l;
      end else if (in_pixel && exp_q.size() == 0) begin
        push_latch();
        if (!cur_last) begin
`ifdef NEO_UNDERRUN_DETECT_EN
          exp_und = 1'b1;
`endif
        end
        in_pixel = 1'b0;
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'($urandom), 1'($urandom), 1'b1);
  endtask

  localparam int FRAME1 = 24 * T_BIT + T_LATCH;

  initial begin
    reset_n         = 1'b0;
    pif.pixel_valid = 1'b0;
    pif.pixel_data  = '0;
    pif.pixel_last  = 1'b0;
    sif.pixel_valid = 1'b0;
    sif.pixel_data  = '0;
    sif.pixel_last  = 1'b0;

    repeat (3) step(1'b0, 24'h0, 1'b0, 1'b0);

    // Single full-green pixel ending the frame.
    step(1'b1, 24'hFF0000, 1'b1, 1'b1);
    drain(FRAME1 + 5);

    // Back-to-back pair with valid held, then a pixel stalled through the latch.
    step(1'b1, 24'hA5A5A5, 1'b0, 1'b1);
    repeat (24 * T_BIT - 1 + 24 * T_BIT + T_LATCH + 3) step(1'b1, 24'h5A5A5A, 1'b1, 1'b1);
    drain(FRAME1 + 5);

    // Underrun after a non-final pixel.
    step(1'b1, 24'h3C96E1, 1'b0, 1'b1);
    drain(FRAME1 + 5);

    // Reset at cycle 500 of a pixel, then a clean restart.
    step(1'b1, 24'hFFFFFF, 1'b0, 1'b1);
    drain(499);
    step(1'b0, 24'h0, 1'b0, 1'b0);
    step(1'b1, 24'hC3C3C3, 1'b1, 1'b1);
    drain(FRAME1 + 5);

    for (int i = 0; i < 25000; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 24'($urandom),
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9999) != 0) ? 1'b1 : 1'b0);
    end
    drain(FRAME1 + 5);

    // Small-parameter instance: pixel 0x000001, last.
    @(negedge clock);
    pif.pixel_valid = 1'b0;
    sif.pixel_valid = 1'b1;
    sif.pixel_data  = 24'h000001;
    sif.pixel_last  = 1'b1;
    #1;
    check("s_ready_idle", sif.pixel_ready, 1'b1);
    @(negedge clock);
    sif.pixel_valid = 1'b0;
    sif.pixel_data  = 24'hFFFFFF;
    #1;
    for (int t = 0; t < 24 * 6 + 10 + 2; t++) begin
      logic e_neo, e_ld, e_busy;
      e_neo  = 1'b0;
      e_ld   = 1'b0;
      e_busy = (t < 24 * 6 + 10);
      if (t < 24 * 6) e_neo = ((t % 6) < (((t / 6) == 23) ? 4 : 2));
      else if (t == 24 * 6 + 9) e_ld = 1'b1;
      check("s_neo_data",   s_neo_data,   e_neo);
      check("s_latch_done", s_latch_done, e_ld);
      check("s_busy",       s_busy,       e_busy);
      @(negedge clock);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neo_bit_encoder.md
# neo_bit_encoder

- Serial line encoder directly downstream of the NeoPixel strand controller.
- Accepts 24-bit {G,R,B} pixel commands over a valid/ready handshake and drives the single-wire NeoPixel waveform on `neo_data`.
- Sends each pixel MSB first (G[7] first). After the last pixel of a frame it holds the line low for the latch interval.
- Timing is in 50 MHz clock cycles.

## Interface
- `T0H`, 18: cycles `neo_data` is high for a 0 bit (0.36 µs).
- `T1H`, 35: cycles `neo_data` is high for a 1 bit (0.70 µs).
- `T_BIT`, 63: total cycles per bit (1.26 µs). Requires T0H < T1H < T_BIT.
- `T_LATCH`, 2750: cycles the line is held low after a frame (55 µs).
- `clock`  in  1  50 MHz system clock; all logic on the rising edge.
- `reset_n`  in  1  Synchronous, active-low reset.
- `pixel_data`  in  24  Pixel command {G[7:0],R[7:0],B[7:0]}.
- `pixel_valid`  in  1  `pixel_data` and `pixel_last` are valid.
- `pixel_last`  in  1  Marks the final pixel of the frame.
- `pixel_ready`  out  1  Encoder accepts a pixel this cycle.
- `neo_data`  out  1  Registered serial output to the strand.
- `busy`  out  1  High in any state other than IDLE.
- `latch_done`  out  1  One-cycle pulse when the latch interval completes.
- `underrun`  out  1  Sticky error flag; see Configuration.

## Operation
- States: IDLE, BIT, LATCH.
- Reset (`reset_n`=0 at a rising edge):
  - state=IDLE, all counters 0.
  - `neo_data`=0, `busy`=0, `latch_done`=0, `underrun`=0.
  - Reset mid-frame aborts immediately; `neo_data` is 0 on the cycle after the reset edge.
- Accept = `pixel_valid` && `pixel_ready` at a rising edge. On accept:
  - load the shift register, set bit index to 23, clear the cycle counter, capture `pixel_last` into `last_q`.
- `pixel_ready` is combinational. It is 1 when:
  - state=IDLE, or
  - state=BIT, bit index=0, cycle counter=T_BIT-1 and `last_q`=0 (back-to-back slot).
  - Otherwise it is 0. It is never 1 in LATCH.
- BIT state:
  - Cycle counter runs 0..T_BIT-1.
  - `neo_data` is 1 while counter < (current bit ? T1H : T0H), otherwise 0.
  - At counter=T_BIT-1 with bit index>0: shift left, decrement bit index, clear the counter.
- At counter=T_BIT-1 with bit index=0, one of:
  - `last_q`=1: go to LATCH.
  - `last_q`=0 and accept: load the next pixel and continue in BIT with no gap cycle.
  - `last_q`=0 and no `pixel_valid`: underrun. Go to LATCH; `underrun` is handled per Configuration.
- LATCH state:
  - `neo_data`=0 for T_LATCH cycles.
  - On the final cycle, `latch_done`=1 for that one cycle only, then go to IDLE.
- Input changes are ignored while `pixel_ready`=0. No pixel is dropped or duplicated.
- Counter widths:
  - cycle counter is $clog2(T_BIT) bits.
  - latch counter is $clog2(T_LATCH+1) bits.
  - Counters never wrap within a state.

## Timing
- Latency: accept at edge N → `neo_data` high from N (registered output is updated on the same edge that accepts).
- High time is exactly T0H or T1H cycles; bit period is exactly T_BIT cycles.
- A pixel lasts 24×T_BIT = 1512 cycles.
- Back-to-back pixels: the next pixel's first high starts at cycle 1512 after the previous pixel started.
- A frame of n pixels: `latch_done` pulses 24·n·T_BIT + T_LATCH − 1 cycles after the first accept edge.
- `busy` rises on the accept edge and falls on the edge after the `latch_done` cycle.
- In IDLE, `neo_data`=0 continuously.

## Configuration
- Macro: `NEO_UNDERRUN_DETECT_EN`.
- Defined:
  - an underrun sets `underrun`=1.
  - It stays 1 until `reset_n`=0.
  - The encoder still enters LATCH normally.
- Undefined:
  - `underrun` is tied to 0.
  - An underrun enters LATCH silently.
  - Waveform timing is identical in both builds.

## Test plan
- Single pixel 0xFF0000, `pixel_last`=1:
  - G bits: 8 pulses, each high 35 / low 28.
  - Then 16 pulses, each high 18 / low 45.
  - Then 2750 low cycles.
  - `latch_done` pulse at cycle 1512+2749.
- Two pixels 0xA5A5A5 then 0x5A5A5A, second with `pixel_last`=1, valid held:
  - `pixel_ready` pulses exactly at cycle 1511.
  - No gap between the two pixels.
  - Decoded bitstream matches both words MSB first.
- Underrun: one pixel with `pixel_last`=0, `pixel_valid` dropped afterwards:
  - LATCH entered at cycle 1512.
  - `underrun`=1 with `NEO_UNDERRUN_DETECT_EN` defined, 0 without it.
- Reset mid-frame: `reset_n`=0 at cycle 500 of a pixel:
  - next cycle `neo_data`=0, `busy`=0, `pixel_ready`=1.
  - A new pixel is accepted cleanly afterwards.
- Handshake stalls:
  - `pixel_valid` held high during LATCH: `pixel_ready`=0 throughout; the pixel is accepted on the first IDLE cycle.
  - `pixel_data` toggled while `pixel_ready`=0: no effect on `neo_data`.
- Parameter override T0H=2, T1H=4, T_BIT=6, T_LATCH=10, pixel 0x000001 last:
  - 23 periods of high 2 / low 4, then one period of high 4 / low 2.
  - Then 10 low cycles.
